// File: rtl/z16_pkg.sv
// Shared types and constants for the Z16 memory arbiter slice.
package z16_pkg;

  localparam int unsigned Z16_WORD_W = 16;
  localparam logic [Z16_WORD_W-1:0] Z16_NOP = 16'h0000;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_IF,
    RESP_DREAD,
    RESP_DERR
  } resp_owner_t;

endpackage

// File: rtl/z16_mem_arbiter_if.sv
// Fetch port, LOAD/STORE port and RAM-side signals of the Z16 memory arbiter.
interface z16_mem_arbiter_if
  import z16_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
);

  logic                  i_if_req;
  logic [Z16_WORD_W-1:0] i_if_addr;
  logic                  o_if_gnt;
  logic                  o_if_rvalid;
  logic [Z16_WORD_W-1:0] o_if_rdata;

  logic                  i_d_req;
  logic                  i_d_we;
  logic [Z16_WORD_W-1:0] i_d_addr;
  logic [Z16_WORD_W-1:0] i_d_wdata;
  logic                  o_d_gnt;
  logic                  o_d_rvalid;
  logic [Z16_WORD_W-1:0] o_d_rdata;
  logic                  o_d_err;

  logic                  o_mem_en;
  logic                  o_mem_we;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [Z16_WORD_W-1:0] o_mem_wdata;
  logic [Z16_WORD_W-1:0] i_mem_rdata;

  modport master (
    output i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport slave (
    input  i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/z16_starve_counter.sv
// Counts consecutive denied fetch cycles and forces a fetch grant at MAX_STARVE.
module z16_starve_counter #(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_force
);

  localparam int unsigned CW = $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_STARVE);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_req || i_gnt) begin
      cnt_q <= '0;
    end else if (cnt_q != MAX_C) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_force = i_req && (cnt_q == MAX_C);

endmodule

// File: rtl/z16_mem_arbiter.sv
// Single-port RAM arbiter for Z16 fetch and LOAD/STORE ports.
// Optional fetch anti-starvation enabled by defining Z16_ARB_FAIR_EN.
module z16_mem_arbiter
  import z16_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  z16_mem_arbiter_if.slave bus
);

  logic if_req, d_req, d_mis, force_if, if_gnt, d_gnt;
  resp_owner_t owner_q, owner_d;
  logic [Z16_WORD_W-1:0] if_rdata_q, d_rdata_q;
  logic unused_ok;

  // Requests are masked during reset so the reset cycle itself shows idle outputs.
  assign if_req    = bus.i_if_req & ~i_rst;
  assign d_req     = bus.i_d_req & ~i_rst;
  assign d_mis     = bus.i_d_addr[0];
  assign unused_ok = bus.i_if_addr[0];

`ifdef Z16_ARB_FAIR_EN
  z16_starve_counter #(.MAX_STARVE(MAX_STARVE)) u_starve (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (if_req),
    .i_gnt   (if_gnt),
    .o_force (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  assign d_gnt        = d_req & ~force_if;
  assign if_gnt       = if_req & ~d_gnt;
  assign bus.o_if_gnt = if_gnt;
  assign bus.o_d_gnt  = d_gnt;

  always_comb begin
    bus.o_mem_en    = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    if (d_gnt) begin
      if (!d_mis) begin
        bus.o_mem_en    = 1'b1;
        bus.o_mem_we    = bus.i_d_we;
        bus.o_mem_addr  = bus.i_d_addr[ADDR_W:1];
        bus.o_mem_wdata = bus.i_d_we ? bus.i_d_wdata : '0;
      end
    end else if (if_gnt) begin
      bus.o_mem_en   = 1'b1;
      bus.o_mem_addr = bus.i_if_addr[ADDR_W:1];
    end
  end

  always_comb begin
    owner_d = RESP_NONE;
    if (d_gnt) begin
      if (d_mis)              owner_d = RESP_DERR;
      else if (!bus.i_d_we)   owner_d = RESP_DREAD;
    end else if (if_gnt) begin
      owner_d = RESP_IF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_q    <= RESP_NONE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == RESP_IF)    if_rdata_q <= bus.i_mem_rdata;
      if (owner_q == RESP_DREAD) d_rdata_q  <= bus.i_mem_rdata;
    end
  end

  // Read data passes straight through on delivery and is held from a register otherwise.
  assign bus.o_if_rvalid = ~i_rst & (owner_q == RESP_IF);
  assign bus.o_d_rvalid  = ~i_rst & (owner_q == RESP_DREAD);
  assign bus.o_d_err     = ~i_rst & (owner_q == RESP_DERR);
  assign bus.o_if_rdata  = i_rst ? '0 : (owner_q == RESP_IF)    ? bus.i_mem_rdata : if_rdata_q;
  assign bus.o_d_rdata   = i_rst ? '0 : (owner_q == RESP_DREAD) ? bus.i_mem_rdata : d_rdata_q;

endmodule
